// File: rtl/branch_predictor_pkg.sv
// Shared predictor types: branch kinds, the IF-side prediction record,
// the EXE-side resolution record, and the 2-bit counter helpers.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        BIsNone = 2'd0,
        BIsImme = 2'd1,
        BIsCall = 2'd2,
        BIsRetn = 2'd3
    } btype_e;

    typedef struct packed {
        logic        valid;
        logic        hit;
        btype_e      btype;
        logic [1:0]  count;
        logic [31:0] target;
    } presult_t;

    typedef struct packed {
        logic        valid;
        logic        hit;
        btype_e      btype;
        logic        is_taken;
        logic [31:0] target;
        logic [31:0] pc;
        logic [1:0]  count;
        logic        retn_success;
    } bresult_t;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/branch_predictor_ras.sv
// Return-address stack: circular buffer, a push when full overwrites the
// oldest slot and the occupancy count saturates at RAS_DEPTH.
module ras_stack #(
    parameter int RAS_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_data,
    output logic [31:0] top,
    output logic        empty
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [RAS_DEPTH-1:0][31:0] mem;
    logic [PTR_W-1:0]           ptr;   // next free slot
    logic [CNT_W-1:0]           cnt;

    assign top   = mem[ptr - 1'b1];
    assign empty = (cnt == '0);

    // storage write; contents are meaningless while cnt is 0, so no reset
    always_ff @(posedge clk) begin
        if (push) mem[ptr] <= push_data;
    end

    // pointer and occupancy; push wins if both are ever asserted
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push) begin
            ptr <= ptr + 1'b1;
            if (cnt != CNT_W'(RAS_DEPTH)) cnt <= cnt + 1'b1;
        end else if (pop && !empty) begin
            ptr <= ptr - 1'b1;
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// IF-stage predictor: direct-mapped BTB with per-entry 2-bit counter and
// branch type, plus a RAS for returns. Prediction is registered (1 cycle).
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int BTB_ENTRIES = 64,
    parameter int TAG_W       = 8,
    parameter int RAS_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IF_PC,
    input  logic        IF_Req,
    input  logic        IF_Stall,
    output presult_t    IF_PResult,
    output logic        IF_PredTaken,
    input  bresult_t    EXE_BResult
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);

    logic [BTB_ENTRIES-1:0]             btb_valid;
    logic [BTB_ENTRIES-1:0][TAG_W-1:0]  btb_tag;
    logic [BTB_ENTRIES-1:0][1:0]        btb_type;
    logic [BTB_ENTRIES-1:0][1:0]        btb_cnt;
    logic [BTB_ENTRIES-1:0][31:0]       btb_target;

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic             l_hit, lookup_en;
    btype_e           l_type;
    logic [31:0]      pc_plus8, ras_top;
    logic             ras_empty, ras_push, ras_pop;
    presult_t         nxt_pres;
    logic             nxt_taken;
    logic [1:0]       u_cnt;

    assign l_idx     = IF_PC[IDX_W+1:2];
    assign l_tag     = IF_PC[IDX_W+TAG_W+1:IDX_W+2];
    assign l_hit     = btb_valid[l_idx] && (btb_tag[l_idx] == l_tag);
    assign l_type    = l_hit ? btype_e'(btb_type[l_idx]) : BIsNone;
    assign pc_plus8  = IF_PC + 32'd8;
    assign lookup_en = IF_Req && !IF_Stall && l_hit;

    // next prediction and RAS side effects for the PC being fetched
    always_comb begin
        nxt_pres        = '0;
        nxt_pres.valid  = IF_Req;
        nxt_pres.hit    = l_hit;
        nxt_pres.btype  = l_type;
        nxt_pres.count  = l_hit ? btb_cnt[l_idx] : 2'b01;
        nxt_pres.target = pc_plus8;
        nxt_taken       = 1'b0;
        ras_push        = 1'b0;
        ras_pop         = 1'b0;
        case (l_type)
            BIsImme: begin
                if (btb_cnt[l_idx][1]) begin
                    nxt_pres.target = btb_target[l_idx];
                    nxt_taken       = 1'b1;
                end
            end
            BIsCall: begin
                nxt_pres.target = btb_target[l_idx];
                nxt_taken       = 1'b1;
                ras_push        = lookup_en;
            end
            BIsRetn: begin
                // empty RAS falls back to the last resolved return target
                nxt_pres.target = ras_empty ? btb_target[l_idx] : ras_top;
                nxt_taken       = 1'b1;
                ras_pop         = lookup_en && !ras_empty;
            end
            default: ;
        endcase
    end

    ras_stack #(.RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus8),
        .top       (ras_top),
        .empty     (ras_empty)
    );

    // registered prediction, frozen while fetch is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            IF_PResult   <= '0;
            IF_PredTaken <= 1'b0;
        end else if (!IF_Stall) begin
            IF_PResult   <= nxt_pres;
            IF_PredTaken <= nxt_taken && IF_Req;
        end
    end

    assign u_idx = EXE_BResult.pc[IDX_W+1:2];
    assign u_tag = EXE_BResult.pc[IDX_W+TAG_W+1:IDX_W+2];
    assign u_cnt = EXE_BResult.hit
                 ? (EXE_BResult.is_taken ? sat_inc(EXE_BResult.count) : sat_dec(EXE_BResult.count))
                 : (EXE_BResult.is_taken ? 2'b10 : 2'b01);

    // valid bits: a resolved non-branch that hit is an alias and is evicted
    always_ff @(posedge clk) begin
        if (rst) begin
            btb_valid <= '0;
        end else if (EXE_BResult.valid) begin
            if (EXE_BResult.btype != BIsNone)
                btb_valid[u_idx] <= 1'b1;
            else if (EXE_BResult.hit)
                btb_valid[u_idx] <= 1'b0;
        end
    end

    // entry payload; guarded by valid so it needs no reset
    always_ff @(posedge clk) begin
        if (EXE_BResult.valid && EXE_BResult.btype != BIsNone) begin
            btb_tag[u_idx]    <= u_tag;
            btb_type[u_idx]   <= EXE_BResult.btype;
            btb_target[u_idx] <= EXE_BResult.target;
            btb_cnt[u_idx]    <= u_cnt;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: reset, BTB train/lookup, RAS
// call/return and overflow, alias eviction, stall hold, mid-stream reset.
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] IF_PC;
    logic        IF_Req;
    logic        IF_Stall;
    presult_t    IF_PResult;
    logic        IF_PredTaken;
    bresult_t    EXE_BResult;

    int total = 0;
    int bad   = 0;

    branch_predictor dut (
        .clk          (clk),
        .rst          (rst),
        .IF_PC        (IF_PC),
        .IF_Req       (IF_Req),
        .IF_Stall     (IF_Stall),
        .IF_PResult   (IF_PResult),
        .IF_PredTaken (IF_PredTaken),
        .EXE_BResult  (EXE_BResult)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc);
        IF_Req = 1'b1;
        IF_PC  = pc;
        tick();
        IF_Req = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pc, input btype_e t, input logic tk,
                       input logic [31:0] tgt, input logic h, input logic [1:0] c);
        EXE_BResult = '{valid: 1'b1, hit: h, btype: t, is_taken: tk, target: tgt,
                        pc: pc, count: c, retn_success: 1'b0};
        tick();
        EXE_BResult = '0;
    endtask

    task automatic chk_pred(input string tag, input logic hit, input logic [1:0] cnt,
                            input logic [31:0] tgt, input logic tk);
        chk({tag, ".valid"}, 64'(IF_PResult.valid), 64'd1);
        chk({tag, ".hit"},   64'(IF_PResult.hit), 64'(hit));
        chk({tag, ".count"}, 64'(IF_PResult.count), 64'(cnt));
        chk({tag, ".target"},64'(IF_PResult.target), 64'(tgt));
        chk({tag, ".taken"}, 64'(IF_PredTaken), 64'(tk));
    endtask

    initial begin
        rst = 1'b1; IF_PC = '0; IF_Req = 1'b0; IF_Stall = 1'b0; EXE_BResult = '0;
        tick(); tick();
        chk("rst.pres",  64'(IF_PResult), 64'd0);
        chk("rst.taken", 64'(IF_PredTaken), 64'd0);
        rst = 1'b0;

        // 1: cold miss
        lookup(32'hBFC00000);
        chk_pred("t1", 1'b0, 2'b01, 32'hBFC00008, 1'b0);
        chk("t1.type", 64'(IF_PResult.btype), 64'(BIsNone));

        // 2: train imme taken, then two not-taken
        upd(32'h80000010, BIsImme, 1'b1, 32'h80000100, 1'b0, 2'b01);
        lookup(32'h80000010);
        chk_pred("t2a", 1'b1, 2'b10, 32'h80000100, 1'b1);
        chk("t2a.type", 64'(IF_PResult.btype), 64'(BIsImme));
        upd(32'h80000010, BIsImme, 1'b0, 32'h80000100, 1'b1, 2'b10);
        upd(32'h80000010, BIsImme, 1'b0, 32'h80000100, 1'b1, 2'b01);
        lookup(32'h80000010);
        chk_pred("t2b", 1'b1, 2'b00, 32'h80000018, 1'b0);

        // 3: call then return through the RAS
        upd(32'h80000020, BIsCall, 1'b1, 32'h80000200, 1'b0, 2'b01);
        upd(32'h80000204, BIsRetn, 1'b1, 32'h80000F00, 1'b0, 2'b01);
        lookup(32'h80000020);
        chk_pred("t3.call", 1'b1, 2'b10, 32'h80000200, 1'b1);
        lookup(32'h80000204);
        chk_pred("t3.retn", 1'b1, 2'b10, 32'h80000028, 1'b1);
        lookup(32'h80000204);
        chk("t3.empty", 64'(IF_PResult.target), 64'h80000F00);

        // 4: nine calls overflow the 8-deep RAS
        for (int k = 1; k <= 9; k++) begin
            upd(32'(k * 32'h100), BIsCall, 1'b1, 32'h5000, 1'b0, 2'b01);
            lookup(32'(k * 32'h100));
            chk($sformatf("t4.call%0d", k), 64'(IF_PResult.target), 64'h5000);
        end
        upd(32'h3004, BIsRetn, 1'b1, 32'h7000, 1'b0, 2'b01);
        for (int k = 9; k >= 2; k--) begin
            lookup(32'h3004);
            chk($sformatf("t4.retn%0d", k), 64'(IF_PResult.target), 64'(k * 32'h100 + 32'h8));
        end
        lookup(32'h3004);
        chk("t4.empty", 64'(IF_PResult.target), 64'h7000);
        chk("t4.taken", 64'(IF_PredTaken), 64'd1);

        // 5: alias eviction, then same-cycle update+lookup sees old entry
        upd(32'h80000010, BIsNone, 1'b0, 32'h0, 1'b1, 2'b00);
        lookup(32'h80000010);
        chk_pred("t5.evict", 1'b0, 2'b01, 32'h80000018, 1'b0);
        upd(32'h80000040, BIsImme, 1'b1, 32'h80000400, 1'b0, 2'b01);
        EXE_BResult = '{valid: 1'b1, hit: 1'b1, btype: BIsNone, is_taken: 1'b0,
                        target: 32'h0, pc: 32'h80000040, count: 2'b10, retn_success: 1'b0};
        lookup(32'h80000040);
        EXE_BResult = '0;
        chk_pred("t5.same", 1'b1, 2'b10, 32'h80000400, 1'b1);
        lookup(32'h80000040);
        chk_pred("t5.after", 1'b0, 2'b01, 32'h80000048, 1'b0);

        // 6: stall on a call lookup holds outputs and pushes once
        lookup(32'h80000020);
        IF_Req = 1'b1; IF_PC = 32'h80000020; IF_Stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("t6.hold%0d", k), 64'(IF_PResult.target), 64'h80000200);
            IF_PC = 32'hBFC00000;
        end
        chk("t6.hold.taken", 64'(IF_PredTaken), 64'd1);
        IF_PC = 32'h80000020;
        IF_Req = 1'b0; IF_Stall = 1'b0;
        tick();
        chk("t6.unstall.valid", 64'(IF_PResult.valid), 64'd0);
        lookup(32'h3004);
        chk("t6.retn1", 64'(IF_PResult.target), 64'h80000028);
        lookup(32'h3004);
        chk("t6.retn2", 64'(IF_PResult.target), 64'h7000);

        // mid-stream reset clears outputs and the BTB
        IF_Req = 1'b1; IF_PC = 32'h80000020; rst = 1'b1;
        tick();
        chk("t6.rst.pres",  64'(IF_PResult), 64'd0);
        chk("t6.rst.taken", 64'(IF_PredTaken), 64'd0);
        rst = 1'b0; IF_Req = 1'b0;
        lookup(32'h80000020);
        chk_pred("t6.post.call", 1'b0, 2'b01, 32'h80000028, 1'b0);
        lookup(32'h3004);
        chk_pred("t6.post.retn", 1'b0, 2'b01, 32'h0000300C, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
